coll_pair_sched: RTL and testbench
==================================

Name: coll_pair_sched

Overview:
- Pair scheduler sequencing the shared collision-detect core across an object table.
- Holds N_OBJ object states (position, velocity) and a global r2 radius-squared term.
- On start, issues every unordered pair (i<j) to the core via a start/done handshake and reports each hit on a ready/valid stream.
- Sits between the host-side object loader and one collision-detect core instance.

Parameters:
- N_OBJ, 8, number of object slots (2..64).
- W, 16, width of coordinate, velocity and r2 fields.
- IDX_W, $clog2(N_OBJ), object index width (derived, not overridden).
- TIMEOUT, 64, max core-response cycles; used only with the optional feature.

Ports:
- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  object table write strobe
- wr_idx  in  IDX_W  slot written
- wr_x, wr_y, wr_vx, wr_vy  in  W each  object state written
- r2  in  W  radius-squared term, latched on accepted start
- start  in  1  begin a full pair sweep
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse when sweep ends
- core_start  out  1  one-cycle pulse to core
- core_x1, core_y1, core_vx1, core_vy1, core_x2, core_y2, core_vx2, core_vy2, core_r2  out  W each  core operands
- core_done  in  1  core result-valid pulse
- core_hit  in  1  core result, sampled with core_done
- hit_valid  out  1  hit report valid
- hit_ready  in  1  consumer accepts hit
- hit_i, hit_j  out  IDX_W each  colliding pair, hit_i < hit_j
- hit_count  out  IDX_W*2  hits in current/last sweep
- err  out  1  sticky timeout flag (0 unless feature enabled)

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; table contents undefined.
- FSM states and transitions:
  - IDLE: start accepted only here. Latches r2, clears hit_count and err, sets i=0, j=1, goes to ISSUE.
  - ISSUE: registers operands of slot i (set 1) and slot j (set 2). Asserts core_start for exactly one cycle, goes to WAIT.
  - WAIT: core_done sampled only here. If core_hit=1, increment hit_count and go to REPORT; else go to ADV.
  - REPORT: hit_valid=1 with hit_i=i, hit_j=j, held stable until hit_ready=1 (transfer cycle). Then go to ADV. hit_valid may not drop without a transfer.
  - ADV: if j==N_OBJ-1, then i++, j=i+1. Else j++. If last pair (N_OBJ-2, N_OBJ-1) has completed, go to FIN; else go to ISSUE.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- Latency: core_start asserts the 2nd cycle after start is sampled. Core operands stay stable from core_start until the cycle after core_done.
- busy=1 from the cycle after start acceptance through the cycle before done.
- Pair order: lexicographic, (0,1),(0,2)…(0,N-1),(1,2)…. Total N_OBJ*(N_OBJ-1)/2 core calls.
- Boundary conditions:
  - Table writes: accepted only when busy=0; ignored while busy. A write and a start in the same IDLE cycle: the write lands first and the sweep uses the new data.
  - core_done outside WAIT is ignored.
  - start while busy is ignored.
  - hit_count does not wrap: max N(N-1)/2 fits IDX_W*2 bits.
  - rst_n low mid-sweep: immediate return to IDLE, all outputs cleared, no done pulse.
- All arithmetic is index counting only; no datapath math in this block.

Optional Feature:
- Macro: COLL_PAIR_SCHED_TIMEOUT_EN.
- Defined: a WAIT-state counter cleared on entry. If TIMEOUT cycles elapse without core_done, set err=1 (sticky until the next accepted start), treat the pair as a no-hit, and go to ADV.
- Undefined: no counter; WAIT blocks indefinitely; err tied 0.

Decomposition:
- Shared package coll_pkg: FSM state enum (IDLE, ISSUE, WAIT, REPORT, ADV, FIN) and an object struct {x,y,vx,vy} of width W. Default constants N_OBJ_DEF=8 and W_DEF=16.
- One natural sub-module, coll_obj_table: a dual-read, single-write register array with a write-enable gated by ~busy.
- FSM and pair counters stay in the top.

Test Plan:
- N_OBJ=4, core model always core_hit=0 with 3-cycle latency → exactly 6 core_start pulses in order (0,1),(0,2),(0,3),(1,2),(1,3),(2,3); one done pulse; hit_count=0.
- Core returns hit only for pair (1,3), hit_ready tied 1 → one hit_valid with hit_i=1, hit_j=3; hit_count=1.
- Same as above but hit_ready held low 10 cycles → hit_valid, hit_i and hit_j stable for 10 cycles; no further core_start until transfer.
- Write slot 2 x=0x0040 while busy, then sweep again → operands for slot 2 show the pre-sweep value on the first sweep and 0x0040 on the second only if rewritten while idle.
- rst_n asserted low during WAIT of pair (0,2) → busy, core_start and hit_valid are 0 immediately; a new start restarts at pair (0,1).
- COLL_PAIR_SCHED_TIMEOUT_EN, TIMEOUT=64, core silent on pair (0,1) → err=1 at cycle 64 of WAIT; sweep continues with (0,2); done still pulses.

Source files
------------

// File: rtl/coll_pkg.sv
// Shared types and defaults for the collision pair scheduler.
package coll_pkg;

  localparam int unsigned N_OBJ_DEF = 8;
  localparam int unsigned W_DEF     = 16;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StReport,
    StAdv,
    StFin
  } state_e;

  typedef struct packed {
    logic [W_DEF-1:0] x;
    logic [W_DEF-1:0] y;
    logic [W_DEF-1:0] vx;
    logic [W_DEF-1:0] vy;
  } obj_t;

endpackage

// File: rtl/coll_obj_table.sv
// Object state table: one write port (blocked while a sweep runs), two combinational reads.
module coll_obj_table
  import coll_pkg::*;
#(
  parameter int unsigned N_OBJ = N_OBJ_DEF,
  parameter int unsigned IDX_W = $clog2(N_OBJ),
  parameter type         ObjT  = obj_t
) (
  input  logic             clock,
  input  logic             busy,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  ObjT              wr_obj,
  input  logic [IDX_W-1:0] rd_idx_a,
  input  logic [IDX_W-1:0] rd_idx_b,
  output ObjT              rd_obj_a,
  output ObjT              rd_obj_b
);

  ObjT mem [N_OBJ];

  // Contents are deliberately not reset; out-of-range slots are dropped.
  always_ff @(posedge clock) begin
    if (wr_en && !busy && (32'(wr_idx) < N_OBJ)) begin
      mem[wr_idx] <= wr_obj;
    end
  end

  assign rd_obj_a = mem[rd_idx_a];
  assign rd_obj_b = mem[rd_idx_b];

endmodule

// File: rtl/coll_pair_sched.sv
// Sweeps all unordered object pairs through one collision core and streams out hits.
// Optional WAIT timeout with sticky err: define COLL_PAIR_SCHED_TIMEOUT_EN.
module coll_pair_sched
  import coll_pkg::*;
#(
  parameter int unsigned N_OBJ   = N_OBJ_DEF,
  parameter int unsigned W       = W_DEF,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned IDX_W  = $clog2(N_OBJ)
) (
  input  logic               clock,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [W-1:0]       wr_x,
  input  logic [W-1:0]       wr_y,
  input  logic [W-1:0]       wr_vx,
  input  logic [W-1:0]       wr_vy,
  input  logic [W-1:0]       r2,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               core_start,
  output logic [W-1:0]       core_x1,
  output logic [W-1:0]       core_y1,
  output logic [W-1:0]       core_vx1,
  output logic [W-1:0]       core_vy1,
  output logic [W-1:0]       core_x2,
  output logic [W-1:0]       core_y2,
  output logic [W-1:0]       core_vx2,
  output logic [W-1:0]       core_vy2,
  output logic [W-1:0]       core_r2,
  input  logic               core_done,
  input  logic               core_hit,
  output logic               hit_valid,
  input  logic               hit_ready,
  output logic [IDX_W-1:0]   hit_i,
  output logic [IDX_W-1:0]   hit_j,
  output logic [IDX_W*2-1:0] hit_count,
  output logic               err
);

  localparam int unsigned CntW = IDX_W * 2;

  typedef struct packed {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] vx;
    logic [W-1:0] vy;
  } obj_w_t;

  if (N_OBJ < 2 || N_OBJ > 64 || TIMEOUT < 1) begin : g_param_check
    $error("coll_pair_sched: parameter out of range");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] i_q, j_q;
  logic [CntW-1:0]  hit_cnt_q;
  logic [W-1:0]     r2_q;
  logic             core_start_q;
  obj_w_t           op_a_q, op_b_q;
  obj_w_t           rd_a, rd_b, wr_obj;
  logic             last_pair;
  logic             tmo_hit;

  assign wr_obj = '{x: wr_x, y: wr_y, vx: wr_vx, vy: wr_vy};

  coll_obj_table #(
    .N_OBJ (N_OBJ),
    .IDX_W (IDX_W),
    .ObjT  (obj_w_t)
  ) u_table (
    .clock    (clock),
    .busy     (busy),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_obj   (wr_obj),
    .rd_idx_a (i_q),
    .rd_idx_b (j_q),
    .rd_obj_a (rd_a),
    .rd_obj_b (rd_b)
  );

  assign last_pair = (i_q == IDX_W'(N_OBJ - 2)) && (j_q == IDX_W'(N_OBJ - 1));

`ifdef COLL_PAIR_SCHED_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
  logic [TmoW-1:0] tmo_q;
  logic            err_q;

  assign tmo_hit = (state_q == StWait) && !core_done && (tmo_q == TmoW'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == StIssue) begin
        tmo_q <= '0;
      end else if (state_q == StWait) begin
        tmo_q <= tmo_q + TmoW'(1);
      end
      if (state_q == StIdle && start) begin
        err_q <= 1'b0;
      end else if (tmo_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    busy      = 1'b0;
    done      = 1'b0;
    hit_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StIssue;
      end
      StIssue: begin
        busy    = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        busy = 1'b1;
        if (core_done) begin
          state_d = core_hit ? StReport : StAdv;
        end else if (tmo_hit) begin
          state_d = StAdv;
        end
      end
      StReport: begin
        busy      = 1'b1;
        hit_valid = 1'b1;
        if (hit_ready) state_d = StAdv;
      end
      StAdv: begin
        busy    = 1'b1;
        state_d = last_pair ? StFin : StIssue;
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      i_q          <= '0;
      j_q          <= '0;
      hit_cnt_q    <= '0;
      r2_q         <= '0;
      core_start_q <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
    end else begin
      core_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            r2_q      <= r2;
            hit_cnt_q <= '0;
            i_q       <= '0;
            j_q       <= IDX_W'(1);
          end
        end
        StIssue: begin
          op_a_q       <= rd_a;
          op_b_q       <= rd_b;
          core_start_q <= 1'b1;
        end
        StWait: begin
          if (core_done && core_hit) hit_cnt_q <= hit_cnt_q + CntW'(1);
        end
        StAdv: begin
          if (!last_pair) begin
            if (j_q == IDX_W'(N_OBJ - 1)) begin
              i_q <= i_q + IDX_W'(1);
              j_q <= i_q + IDX_W'(2);
            end else begin
              j_q <= j_q + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign core_start = core_start_q;
  assign core_x1    = op_a_q.x;
  assign core_y1    = op_a_q.y;
  assign core_vx1   = op_a_q.vx;
  assign core_vy1   = op_a_q.vy;
  assign core_x2    = op_b_q.x;
  assign core_y2    = op_b_q.y;
  assign core_vx2   = op_b_q.vx;
  assign core_vy2   = op_b_q.vy;
  assign core_r2    = r2_q;
  assign hit_i      = i_q;
  assign hit_j      = j_q;
  assign hit_count  = hit_cnt_q;

endmodule

// File: tb/tb_coll_pair_sched.sv
// Scoreboard bench for coll_pair_sched with N_OBJ=4 and a behavioural collision core.
`timescale 1ns/1ps
module tb_coll_pair_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned IW = 2;

  typedef logic [143:0] ops_t;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [W-1:0]  wr_x, wr_y, wr_vx, wr_vy, r2;
  logic          start;
  logic          busy, done, core_start;
  logic [W-1:0]  core_x1, core_y1, core_vx1, core_vy1;
  logic [W-1:0]  core_x2, core_y2, core_vx2, core_vy2, core_r2;
  logic          core_done, core_hit;
  logic          hit_valid, hit_ready;
  logic [IW-1:0] hit_i, hit_j;
  logic [2*IW-1:0] hit_count;
  logic          err;

  always #5 clock = ~clock;

  coll_pair_sched #(
    .N_OBJ   (N),
    .W       (W),
    .TIMEOUT (64)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_vx      (wr_vx),
    .wr_vy      (wr_vy),
    .r2         (r2),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .core_start (core_start),
    .core_x1    (core_x1),
    .core_y1    (core_y1),
    .core_vx1   (core_vx1),
    .core_vy1   (core_vy1),
    .core_x2    (core_x2),
    .core_y2    (core_y2),
    .core_vx2   (core_vx2),
    .core_vy2   (core_vy2),
    .core_r2    (core_r2),
    .core_done  (core_done),
    .core_hit   (core_hit),
    .hit_valid  (hit_valid),
    .hit_ready  (hit_ready),
    .hit_i      (hit_i),
    .hit_j      (hit_j),
    .hit_count  (hit_count),
    .err        (err)
  );

  // Reference model of the table and sweep configuration.
  logic [W-1:0] mx [N], my [N], mvx [N], mvy [N];
  logic [W-1:0] cur_r2;
  logic [15:0]  hmask, smask;

  ops_t        exp_ops [$];
  logic [3:0]  exp_hits [$];
  logic [3:0]  exp_done [$];
  ops_t        last_ops;
  int          n_checks = 0;
  int          n_pass = 0;
  int          done_cnt = 0;

  int          core_cnt;
  logic        core_ph;
  int          ci, cj;

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  function automatic ops_t pair_ops(input int i, input int j);
    return {mx[i], my[i], mvx[i], mvy[i], mx[j], my[j], mvx[j], mvy[j], cur_r2};
  endfunction

  function automatic ops_t dut_ops();
    return {core_x1, core_y1, core_vx1, core_vy1, core_x2, core_y2, core_vx2, core_vy2,
            core_r2};
  endfunction

  // Core model: responds 3 cycles after core_start; pair identified by y low nibble.
  initial begin
    core_done = 1'b0;
    core_hit  = 1'b0;
    core_cnt  = 0;
    core_ph   = 1'b0;
    forever begin
      @(negedge clock);
      core_done = 1'b0;
      core_hit  = 1'b0;
      if (!rst_n) begin
        core_cnt = 0;
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          core_done = 1'b1;
          core_hit  = core_ph;
        end
      end
      if (rst_n && core_start) begin
        ci = int'(core_y1[3:0]);
        cj = int'(core_y2[3:0]);
        if (!smask[ci*4+cj]) begin
          core_cnt = 3;
          core_ph  = hmask[ci*4+cj];
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (rst_n) begin
        if (core_start) begin
          check("core_start expected", 144'(exp_ops.size() != 0), 144'd1);
          if (exp_ops.size() != 0) begin
            last_ops = exp_ops.pop_front();
            check("core operands", dut_ops(), last_ops);
          end
        end
        if (core_done) check("operands held to core_done", dut_ops(), last_ops);
        if (hit_valid && hit_ready) begin
          check("hit expected", 144'(exp_hits.size() != 0), 144'd1);
          if (exp_hits.size() != 0) check("hit pair", 144'({hit_i, hit_j}), 144'(exp_hits.pop_front()));
        end
        if (done) begin
          done_cnt++;
          check("busy low at done", 144'(busy), 144'd0);
          check("done expected", 144'(exp_done.size() != 0), 144'd1);
          if (exp_done.size() != 0) check("hit_count at done", 144'(hit_count), 144'(exp_done.pop_front()));
        end
      end
    end
  end

  task automatic set_model(input int k, input logic [W-1:0] x);
    mx[k]  = x;
    my[k]  = 16'h0200 + 16'(k);
    mvx[k] = 16'h0300 + 16'(k);
    mvy[k] = 16'h0400 + 16'(k);
  endtask

  task automatic wr(input int k, input logic [W-1:0] x);
    @(negedge clock);
    wr_en  = 1'b1;
    wr_idx = IW'(k);
    wr_x   = x;
    wr_y   = 16'h0200 + 16'(k);
    wr_vx  = 16'h0300 + 16'(k);
    wr_vy  = 16'h0400 + 16'(k);
    @(negedge clock);
    wr_en  = 1'b0;
  endtask

  task automatic load_all();
    for (int k = 0; k < N; k++) begin
      wr(k, 16'h0100 + 16'(k));
      set_model(k, 16'h0100 + 16'(k));
    end
  endtask

  task automatic push_full();
    int c = 0;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        exp_ops.push_back(pair_ops(i, j));
        if (hmask[i*4+j]) begin
          exp_hits.push_back({2'(i), 2'(j)});
          c++;
        end
      end
    end
    exp_done.push_back(4'(c));
  endtask

  task automatic issue_start();
    @(negedge clock);
    r2    = cur_r2;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy after start", 144'(busy), 144'd1);
    check("core_start idle in ISSUE", 144'(core_start), 144'd0);
    @(negedge clock);
    check("core_start 2nd cycle", 144'(core_start), 144'd1);
  endtask

  task automatic wait_done();
    int d0 = done_cnt;
    for (int c = 0; c < 1000 && done_cnt == d0; c++) @(negedge clock);
    check("sweep done within budget", 144'(done_cnt != d0), 144'd1);
  endtask

  task automatic drained();
    check("ops queue drained", 144'(exp_ops.size()), 144'd0);
    check("hit queue drained", 144'(exp_hits.size()), 144'd0);
    check("done queue drained", 144'(exp_done.size()), 144'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_vx = '0; wr_vy = '0;
    r2 = '0; start = 1'b0; hit_ready = 1'b1; hmask = '0; smask = '0; cur_r2 = '0;
    repeat (3) @(negedge clock);
    check("reset outputs", 144'({busy, done, core_start, hit_valid, err, hit_count, hit_i, hit_j}),
          144'd0);
    check("reset operands", dut_ops(), 144'd0);
    rst_n = 1'b1;
    load_all();

    // All misses; a start mid-sweep with a different r2 must be ignored.
    cur_r2 = 16'h0A0A;
    push_full();
    issue_start();
    @(negedge clock);
    r2    = 16'hBEEF;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done();
    drained();
    check("hit_count after miss sweep", 144'(hit_count), 144'd0);

    // Hit only on (1,3), consumer always ready.
    hmask  = 16'h0080;
    cur_r2 = 16'h1234;
    push_full();
    issue_start();
    wait_done();
    drained();
    check("hit_count one hit", 144'(hit_count), 144'd1);

    // Same, consumer stalls for 10 cycles.
    hit_ready = 1'b0;
    push_full();
    issue_start();
    for (int c = 0; c < 200 && !hit_valid; c++) @(negedge clock);
    check("hit_valid raised", 144'(hit_valid), 144'd1);
    for (int c = 0; c < 10; c++) begin
      check("stall hold", 144'({hit_valid, hit_i, hit_j, core_start}), 144'({1'b1, 2'd1, 2'd3, 1'b0}));
      @(negedge clock);
    end
    hit_ready = 1'b1;
    wait_done();
    drained();

    // Write while busy is dropped; write together with start lands first.
    hmask = '0;
    push_full();
    issue_start();
    wr(2, 16'h0040);
    wait_done();
    drained();
    push_full();
    issue_start();
    wait_done();
    drained();
    set_model(2, 16'h0040);
    push_full();
    @(negedge clock);
    r2 = cur_r2; start = 1'b1;
    wr_en = 1'b1; wr_idx = 2'd2; wr_x = 16'h0040; wr_y = 16'h0202; wr_vx = 16'h0302;
    wr_vy = 16'h0402;
    @(negedge clock);
    start = 1'b0; wr_en = 1'b0;
    wait_done();
    drained();

    // Reset during WAIT of (0,2) after a hit on (0,1).
    hmask = 16'h0002;
    smask = 16'h0004;
    exp_ops.push_back(pair_ops(0, 1));
    exp_ops.push_back(pair_ops(0, 2));
    exp_hits.push_back({2'd0, 2'd1});
    issue_start();
    for (int c = 0; c < 200 && exp_ops.size() != 0; c++) @(negedge clock);
    repeat (2) @(negedge clock);
    check("hit_count before reset", 144'(hit_count), 144'd1);
    #2 rst_n = 1'b0;
    #1;
    check("outputs cleared by reset", 144'({busy, done, core_start, hit_valid, hit_count}), 144'd0);
    @(negedge clock);
    rst_n = 1'b1;
    drained();
    hmask = '0;
    smask = '0;
    load_all();
    push_full();
    issue_start();
    wait_done();
    drained();
    check("err stays low", 144'(err), 144'd0);

`ifdef COLL_PAIR_SCHED_TIMEOUT_EN
    // Core silent on (0,1): timeout flags err and the sweep continues.
    smask = 16'h0002;
    push_full();
    issue_start();
    wait_done();
    drained();
    check("err after timeout", 144'(err), 144'd1);
    smask = '0;
    push_full();
    issue_start();
    check("err cleared by start", 144'(err), 144'd0);
    wait_done();
    drained();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
